// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : riscv_pkg
//  Description : Shared definitions for the 5-stage RISC-V core hazard logic:
//                forwarding select encodings and the hazard controller states.
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    // ALU operand source selects driven into the E stage
    localparam logic [1:0] FWD_RF  = 2'b00;  // register file read value
    localparam logic [1:0] FWD_WB  = 2'b01;  // result being written back in W
    localparam logic [1:0] FWD_MEM = 2'b10;  // ALU result sitting in M

    // Hazard controller sequencing states
    typedef enum logic [1:0] {
        BOOT = 2'b00,
        RUN  = 2'b01,
        WAIT = 2'b10
    } hz_state_t;

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_fwd_sel.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_sel
//  Description : Per-operand forwarding comparator. Picks the youngest
//                in-flight producer of a source register; x0 never forwards.
//  Revision    : 1.0 - initial release
// ============================================================================
module fwd_sel
    import riscv_pkg::*;
(
    input  logic [4:0] src,
    input  logic [4:0] rd_m,
    input  logic [4:0] rd_w,
    input  logic       reg_write_m,
    input  logic       reg_write_w,
    output logic [1:0] sel
);

    // M is younger than W, so it is tested first and wins on a tie
    always_comb begin
        sel = FWD_RF;
        if (reg_write_m && (rd_m != 5'd0) && (rd_m == src)) begin
            sel = FWD_MEM;
        end else if (reg_write_w && (rd_w != 5'd0) && (rd_w == src)) begin
            sel = FWD_WB;
        end
    end

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Pipeline hazard and stall controller. Forwarding, load-use
//                bubble, branch flush, data-memory freeze, post-reset boot
//                flush and a sticky memory timeout flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl
    import riscv_pkg::*;
#(
    parameter int BOOT_CYCLES = 2,
    parameter int MAX_WAIT    = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] Rs1D,
    input  logic [4:0] Rs2D,
    input  logic [4:0] Rs1E,
    input  logic [4:0] Rs2E,
    input  logic [4:0] RdE,
    input  logic [4:0] RdM,
    input  logic [4:0] RdW,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic       ResultSrcE0,
    input  logic       PCSrcE,
    input  logic       MemReqM,
    input  logic       DMemReady,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       StallM,
    output logic       FlushD,
    output logic       FlushE,
    output logic       FlushW,
    output logic       MemTimeout
);

    localparam int BW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [BW-1:0] BOOT_LAST = BW'(BOOT_CYCLES - 1);
    localparam logic [WW-1:0] WAIT_MAX  = WW'(MAX_WAIT);

    hz_state_t     state_q, state_d;
    logic [BW-1:0] boot_cnt_q, boot_cnt_d;
    logic [WW-1:0] wait_cnt_q, wait_cnt_d;
    logic          timeout_q, timeout_d;

    logic lw_stall;
    logic mem_stall;
    logic boot;

    fwd_sel u_fwd_a (
        .src         (Rs1E),
        .rd_m        (RdM),
        .rd_w        (RdW),
        .reg_write_m (RegWriteM),
        .reg_write_w (RegWriteW),
        .sel         (ForwardAE)
    );

    fwd_sel u_fwd_b (
        .src         (Rs2E),
        .rd_m        (RdM),
        .rd_w        (RdW),
        .reg_write_m (RegWriteM),
        .reg_write_w (RegWriteW),
        .sel         (ForwardBE)
    );

    // Hazard detection and the combinational stall/flush network
    always_comb begin
        lw_stall  = ResultSrcE0 && (RdE != 5'd0) && ((Rs1D == RdE) || (Rs2D == RdE));
        mem_stall = MemReqM && !DMemReady;
        boot      = (state_q == BOOT);

        StallF = boot || lw_stall || mem_stall;
        StallD = boot || lw_stall || mem_stall;
        StallE = mem_stall;
        StallM = mem_stall;
        FlushW = mem_stall;
        // E is frozen under a memory stall, so the flush request survives
        // until the first unstalled cycle
        FlushE = !mem_stall && (boot || lw_stall || PCSrcE);
        FlushD = !mem_stall && (boot || PCSrcE);
        MemTimeout = timeout_q;
    end

    // Next state, boot countdown, wait counter and sticky timeout
    always_comb begin
        state_d    = state_q;
        boot_cnt_d = boot_cnt_q;
        wait_cnt_d = '0;
        timeout_d  = timeout_q;

        case (state_q)
            BOOT: begin
                if (boot_cnt_q == BOOT_LAST) begin
                    state_d = RUN;
                end else begin
                    boot_cnt_d = boot_cnt_q + BW'(1);
                end
            end
            RUN: begin
                if (mem_stall) state_d = WAIT;
            end
            WAIT: begin
                if (!mem_stall) state_d = RUN;
            end
            default: state_d = BOOT;
        endcase

        // The flag rises on the edge that closes the MAX_WAIT-th stalled cycle
        if (mem_stall) begin
            wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? WAIT_MAX : (wait_cnt_q + WW'(1));
            if (wait_cnt_d == WAIT_MAX) timeout_d = 1'b1;
        end
    end

    // Controller state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= BOOT;
            boot_cnt_q <= '0;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            boot_cnt_q <= boot_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_ctrl
//  Description : Self-checking bench for hazard_ctrl with a behavioural
//                reference model and directed literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    localparam int BOOT_CYCLES = 2;
    localparam int MAX_WAIT    = 15;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [4:0] Rs1D = '0, Rs2D = '0, Rs1E = '0, Rs2E = '0, RdE = '0, RdM = '0, RdW = '0;
    logic       RegWriteM = 1'b0, RegWriteW = 1'b0, ResultSrcE0 = 1'b0;
    logic       PCSrcE = 1'b0, MemReqM = 1'b0, DMemReady = 1'b0;
    logic [1:0] ForwardAE, ForwardBE;
    logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemTimeout;

    hazard_ctrl #(.BOOT_CYCLES(BOOT_CYCLES), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE), .MemReqM(MemReqM),
        .DMemReady(DMemReady),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW), .MemTimeout(MemTimeout)
    );

    always #5 clk = ~clk;

    // Reference model state: boot edges still to go, consecutive stalled
    // cycles, and the sticky timeout
    int   m_boot_left = BOOT_CYCLES;
    int   m_stall_run = 0;
    logic m_tmo       = 1'b0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_boot_left = BOOT_CYCLES;
            m_stall_run = 0;
            m_tmo       = 1'b0;
        end else begin
            if (m_boot_left > 0) m_boot_left = m_boot_left - 1;
            if (MemReqM && !DMemReady) begin
                m_stall_run = m_stall_run + 1;
                if (m_stall_run >= MAX_WAIT) m_tmo = 1'b1;
            end else begin
                m_stall_run = 0;
            end
        end
    end

    function automatic logic [1:0] fwd_of(input logic [4:0] src);
        if (RegWriteM && RdM != 0 && RdM == src) return 2'b10;
        if (RegWriteW && RdW != 0 && RdW == src) return 2'b01;
        return 2'b00;
    endfunction

    // Output vector order: FA[11:10] FB[9:8] SF SD SE SM FD FE FW TO
    function automatic logic [11:0] model_vec();
        logic boot, lw, ms;
        boot = !reset || (m_boot_left > 0);
        lw   = ResultSrcE0 && RdE != 0 && (Rs1D == RdE || Rs2D == RdE);
        ms   = MemReqM && !DMemReady;
        return {fwd_of(Rs1E), fwd_of(Rs2E),
                boot | lw | ms, boot | lw | ms, ms, ms,
                !ms & (boot | PCSrcE), !ms & (boot | lw | PCSrcE), ms, m_tmo};
    endfunction

    wire [11:0] dut_vec = {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
                           FlushD, FlushE, FlushW, MemTimeout};

    int          checks   = 0;
    int          failures = 0;
    logic        lit_req  = 1'b0;
    logic        lit_ack  = 1'b0;
    logic [11:0] lit_exp  = '0;
    string       lit_name = "";

    // Single compare process: model every cycle, plus any pending literal
    always @(negedge clk) begin
        logic [11:0] e;
        e = model_vec();
        checks = checks + 1;
        if (dut_vec !== e) begin
            failures = failures + 1;
            $display("FAIL model t=%0t got=%b want=%b", $time, dut_vec, e);
        end
        if (lit_req != lit_ack) begin
            checks = checks + 1;
            if (dut_vec !== lit_exp) begin
                failures = failures + 1;
                $display("FAIL %s t=%0t got=%b want=%b", lit_name, $time, dut_vec, lit_exp);
            end
            lit_ack = lit_req;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic expect_lit(input string name, input logic [11:0] v);
        lit_name = name;
        lit_exp  = v;
        lit_req  = ~lit_req;
    endtask

    localparam logic [11:0] V_BOOT = 12'b00_00_1100_110_0;
    localparam logic [11:0] V_IDLE = 12'b00_00_0000_000_0;
    localparam logic [11:0] V_MSTL = 12'b00_00_1111_001_0;

    initial begin
        // reset held with all inputs low
        step(); expect_lit("reset_hold", V_BOOT);
        step(); reset = 1'b1; expect_lit("boot_c1", V_BOOT);
        step(); expect_lit("boot_c2", V_BOOT);
        step(); expect_lit("run_idle", V_IDLE);

        // forwarding priority and x0 handling
        step(); RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1; Rs1E = 5;
        expect_lit("fwd_mem", 12'b10_00_0000_000_0);
        step(); RegWriteM = 0; Rs2E = 5;
        expect_lit("fwd_wb", 12'b01_01_0000_000_0);
        step(); Rs1E = 0; Rs2E = 0; RdM = 0; RdW = 0; RegWriteM = 1;
        expect_lit("fwd_x0", V_IDLE);
        step(); RegWriteM = 0; RegWriteW = 0;

        // load-use bubble
        step(); ResultSrcE0 = 1; RdE = 7; Rs2D = 7;
        expect_lit("load_use", 12'b00_00_1100_010_0);
        step(); ResultSrcE0 = 0; RdE = 0; Rs2D = 0;
        expect_lit("load_use_end", V_IDLE);

        // branch flush, then flush held off by a memory stall
        step(); PCSrcE = 1; expect_lit("branch", 12'b00_00_0000_110_0);
        for (int i = 0; i < 3; i++) begin
            step(); MemReqM = 1; DMemReady = 0;
            expect_lit("branch_memstall", V_MSTL);
        end
        step(); DMemReady = 1; expect_lit("branch_release", 12'b00_00_0000_110_0);
        step(); PCSrcE = 0; MemReqM = 0; DMemReady = 0;

        // load-use and redirect in the same cycle
        step(); ResultSrcE0 = 1; RdE = 3; Rs1D = 3; PCSrcE = 1;
        expect_lit("lw_and_branch", 12'b00_00_1100_110_0);
        step(); ResultSrcE0 = 0; RdE = 0; Rs1D = 0; PCSrcE = 0;

        // memory timeout: clear for MAX_WAIT cycles, set after the last edge
        for (int i = 1; i <= MAX_WAIT; i++) begin
            step(); MemReqM = 1; DMemReady = 0;
            if (i == MAX_WAIT) expect_lit("tmo_pre", V_MSTL);
        end
        step(); expect_lit("tmo_set", V_MSTL | 12'b1);
        step(); DMemReady = 1; expect_lit("tmo_sticky", 12'b00_00_0000_000_1);
        step(); MemReqM = 0; DMemReady = 0;

        // reset pulsed mid-WAIT: flag clears, boot flushes suppressed by stall
        for (int i = 0; i < 3; i++) begin
            step(); MemReqM = 1; DMemReady = 0;
        end
        step(); reset = 1'b0; expect_lit("rst_midwait", 12'b00_00_1111_001_0);
        step(); MemReqM = 0; expect_lit("rst_hold2", V_BOOT);
        // stall during the first boot cycle; boot counting continues
        step(); reset = 1'b1; MemReqM = 1; expect_lit("boot_memstall", V_MSTL);
        step(); MemReqM = 0; expect_lit("reboot_c2", V_BOOT);
        step(); expect_lit("reboot_run", V_IDLE);

        step(); step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
